sram_loader: RTL
================

SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter IMAGE_BASE, default 16'h0000, SRAM word address of the first image word.
REQ-002 Parameter IMAGE_WORDS, default 64, number of image words per image load.
REQ-003 Parameter COEF_BASE, default 16'h1000, SRAM word address of coefficient block 0.
REQ-004 Parameter COEF_WORDS, default 16, number of words per coefficient block; SHALL be a power of two.
REQ-005 Parameter NUM_COEF_BLOCKS, default 10, number of coefficient blocks before the block pointer wraps.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 n_rst  input  1  asynchronous, active-low reset.
REQ-008 start_sram  input  1  one-cycle load request from sram_controller.
REQ-009 n_coef_image  input  1  load type: 1 = image, 0 = coefficient block; sampled with start_sram.
REQ-010 sram_read  output  1  SRAM read strobe, one cycle per word.
REQ-011 sram_addr  output  16  SRAM word address, valid while sram_read = 1.
REQ-012 sram_rvalid  input  1  SRAM read-data-valid pulse.
REQ-013 sram_rdata  input  16  SRAM read data, valid when sram_rvalid = 1.
REQ-014 buf_wen  output  1  weight-buffer write enable.
REQ-015 buf_sel  output  1  target buffer: 1 = image buffer, 0 = coefficient buffer.
REQ-016 buf_waddr  output  8  buffer word index, 0 to (word count - 1).
REQ-017 buf_wdata  output  16  buffer write data.
REQ-018 sram_done  output  1  one-cycle pulse when the load completes.

Function
REQ-019 The FSM SHALL use states IDLE, ISSUE, WAIT_DATA, WRITE and DONE.
REQ-020 IDLE: on start_sram = 1, latch mode from n_coef_image, clear the word count to 0, and go to ISSUE.
REQ-021 ISSUE: assert sram_read for exactly one cycle, then go to WAIT_DATA.
REQ-022 Image address SHALL be IMAGE_BASE + count.
REQ-023 Coefficient address SHALL be COEF_BASE + blk*COEF_WORDS + count, computed by shift, truncated to 16 bits.
REQ-024 WAIT_DATA: hold there until sram_rvalid = 1, then register sram_rdata and go to WRITE; sram_rvalid outside WAIT_DATA SHALL be ignored.
REQ-025 WRITE: assert buf_wen for one cycle with buf_waddr = count, buf_wdata = the registered word, and buf_sel = the latched mode.
REQ-026 From WRITE, when count = word count - 1, go to DONE; otherwise increment count and go to ISSUE.
REQ-027 DONE: pulse sram_done for one cycle, then return to IDLE.
REQ-028 A coefficient load SHALL increment blk in DONE, wrapping from NUM_COEF_BLOCKS-1 to 0.
REQ-029 An image load SHALL clear blk to 0 in DONE.
REQ-030 start_sram outside IDLE SHALL be ignored: not queued, and mode is not re-latched.
REQ-031 Minimum latency is 3 cycles per word (ISSUE, one-cycle WAIT_DATA, WRITE), plus 1 cycle for DONE.
REQ-032 At most one SRAM read SHALL be outstanding at any time.
REQ-033 sram_read, buf_wen and sram_done SHALL never be asserted in the same cycle.

Reset
REQ-034 n_rst = 0 SHALL asynchronously force IDLE, with count = 0, blk = 0, mode = 0, the data register = 0 and every output = 0.
REQ-035 Reset during a load SHALL abort it with no sram_done pulse; after reset the block SHALL accept a new start_sram.

Structure
REQ-036 The state enum and the default parameter values SHALL live in shared package cnn_pkg.
REQ-037 The address generator (count, blk, and the wrap logic) SHALL be sub-module sram_addr_gen; the FSM and data register stay in sram_loader.

Verification
REQ-038 Image load, rvalid one cycle after each read -> 64 reads at 0x0000..0x003F, 64 writes with buf_sel = 1, sram_done exactly 193 cycles after start_sram.
REQ-039 Three consecutive coefficient loads -> reads start at 0x1000, 0x1010 and 0x1020, 16 writes each with buf_sel = 0.
REQ-040 Eleven coefficient loads -> the eleventh starts at 0x1000 (wrap); a following image load then a coefficient load -> the coefficient load starts at 0x1000.
REQ-041 rvalid delayed by 5 cycles on word 3 -> FSM stays in WAIT_DATA, no extra sram_read, buf_wdata equals sram_rdata for that word.
REQ-042 start_sram pulsed mid-load and a stray rvalid pulsed in WRITE -> both ignored, and word count and addresses are unchanged.
REQ-043 n_rst asserted at word 10 of an image load -> all outputs 0 immediately and no sram_done; a new image load then starts again at 0x0000.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the SRAM loader slice.
//   loader_state_e  - loader FSM encoding
//   DEF_*           - default parameter values for sram_loader / sram_addr_gen
//   blk_width()     - width of the coefficient block pointer
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } loader_state_e;

    localparam logic [15:0] DEF_IMAGE_BASE      = 16'h0000;
    localparam int          DEF_IMAGE_WORDS     = 64;
    localparam logic [15:0] DEF_COEF_BASE       = 16'h1000;
    localparam int          DEF_COEF_WORDS      = 16;
    localparam int          DEF_NUM_COEF_BLOCKS = 10;

    // A single block still needs a 1-bit pointer so the port stays legal.
    function automatic int blk_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_addr_gen.sv
// sram_addr_gen: word counter, coefficient block pointer and SRAM address.
//   clk, n_rst  - clock, async active-low reset
//   cnt_clr     - clear word count (load accepted)
//   cnt_inc     - advance word count (word written, more to go)
//   blk_step    - load finished: advance block (coef) or clear it (image)
//   mode        - 1 = image, 0 = coefficient
//   count       - current word index
//   last        - count is the final word of the current load
//   addr        - SRAM word address for the current word
import cnn_pkg::*;

module sram_addr_gen #(
    parameter logic [15:0] IMAGE_BASE      = DEF_IMAGE_BASE,
    parameter int          IMAGE_WORDS     = DEF_IMAGE_WORDS,
    parameter logic [15:0] COEF_BASE       = DEF_COEF_BASE,
    parameter int          COEF_WORDS      = DEF_COEF_WORDS,
    parameter int          NUM_COEF_BLOCKS = DEF_NUM_COEF_BLOCKS
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cnt_clr,
    input  logic        cnt_inc,
    input  logic        blk_step,
    input  logic        mode,
    output logic [7:0]  count,
    output logic        last,
    output logic [15:0] addr
);

    localparam int                BLK_W    = blk_width(NUM_COEF_BLOCKS);
    localparam int                CW_SHIFT = $clog2(COEF_WORDS);
    localparam logic [7:0]        IMG_LAST = 8'(IMAGE_WORDS - 1);
    localparam logic [7:0]        CF_LAST  = 8'(COEF_WORDS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(NUM_COEF_BLOCKS - 1);

    logic [BLK_W-1:0] blk;
    logic [15:0]      coef_off;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
            blk   <= '0;
        end else begin
            if (cnt_clr)
                count <= '0;
            else if (cnt_inc)
                count <= count + 8'd1;

            // An image load resets the coefficient sequence to block 0.
            if (blk_step) begin
                if (mode)
                    blk <= '0;
                else if (blk == BLK_LAST)
                    blk <= '0;
                else
                    blk <= blk + BLK_W'(1);
            end
        end
    end

    assign last     = (count == (mode ? IMG_LAST : CF_LAST));
    // COEF_WORDS is a power of two, so blk*COEF_WORDS is a plain shift.
    assign coef_off = 16'(blk) << CW_SHIFT;
    assign addr     = mode ? (IMAGE_BASE + 16'(count))
                           : (COEF_BASE + coef_off + 16'(count));

endmodule

// File: rtl/sram_loader.sv
// sram_loader: copies an image or one coefficient block from SRAM into the
// weight buffers, one word at a time with a single outstanding read.
//   clk, n_rst             - clock, async active-low reset
//   start_sram             - one-cycle load request (honoured only when idle)
//   n_coef_image           - load type sampled with start_sram (1 = image)
//   sram_read, sram_addr   - read strobe and word address
//   sram_rvalid, sram_rdata- read response
//   buf_wen, buf_sel,
//   buf_waddr, buf_wdata   - buffer write port (sel 1 = image buffer)
//   sram_done              - one-cycle completion pulse
import cnn_pkg::*;

module sram_loader #(
    parameter logic [15:0] IMAGE_BASE      = DEF_IMAGE_BASE,
    parameter int          IMAGE_WORDS     = DEF_IMAGE_WORDS,
    parameter logic [15:0] COEF_BASE       = DEF_COEF_BASE,
    parameter int          COEF_WORDS      = DEF_COEF_WORDS,
    parameter int          NUM_COEF_BLOCKS = DEF_NUM_COEF_BLOCKS
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start_sram,
    input  logic        n_coef_image,
    output logic        sram_read,
    output logic [15:0] sram_addr,
    input  logic        sram_rvalid,
    input  logic [15:0] sram_rdata,
    output logic        buf_wen,
    output logic        buf_sel,
    output logic [7:0]  buf_waddr,
    output logic [15:0] buf_wdata,
    output logic        sram_done
);

    loader_state_e state;
    logic          mode;
    logic [15:0]   rdata_q;
    logic [7:0]    count;
    logic          last;
    logic [15:0]   addr;

    sram_addr_gen #(
        .IMAGE_BASE      (IMAGE_BASE),
        .IMAGE_WORDS     (IMAGE_WORDS),
        .COEF_BASE       (COEF_BASE),
        .COEF_WORDS      (COEF_WORDS),
        .NUM_COEF_BLOCKS (NUM_COEF_BLOCKS)
    ) u_addr_gen (
        .clk      (clk),
        .n_rst    (n_rst),
        .cnt_clr  ((state == ST_IDLE) && start_sram),
        .cnt_inc  ((state == ST_WRITE) && !last),
        .blk_step (state == ST_DONE),
        .mode     (mode),
        .count    (count),
        .last     (last),
        .addr     (addr)
    );

    // start_sram is only looked at in IDLE, so a request during a load is
    // dropped and mode cannot change mid-load. rvalid is only looked at in
    // WAIT_DATA, so stray pulses never advance the FSM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            mode    <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_sram) begin
                        mode  <= n_coef_image;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE:     state <= ST_WAIT_DATA;
                ST_WAIT_DATA: begin
                    if (sram_rvalid) begin
                        rdata_q <= sram_rdata;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE:     state <= last ? ST_DONE : ST_ISSUE;
                ST_DONE:      state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state, so they are mutually exclusive and
    // drop to zero the instant reset asserts.
    assign sram_read = (state == ST_ISSUE);
    assign sram_addr = sram_read ? addr : '0;
    assign buf_wen   = (state == ST_WRITE);
    assign buf_sel   = buf_wen & mode;
    assign buf_waddr = buf_wen ? count : '0;
    assign buf_wdata = buf_wen ? rdata_q : '0;
    assign sram_done = (state == ST_DONE);

endmodule
